l2_access_controller: RTL and testbench

- Sequences every access to the 8-way L2 tag/data array and its hit detector.
- Round-robin arbitrates between two requesters: port 0 is L1-I, port 1 is L1-D.
- For each granted request it issues a lookup and samples the hit result.
- On a miss it fetches the line from memory, fills a victim way, then returns the response. It also keeps saturating hit/miss statistics.

---
 rtl/l2_access_controller.sv | 204 ++++++++++++++++++++
 tb/tb_l2_access_controller.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_access_controller.sv
// L2 access sequencer: arbitrates L1-I/L1-D, looks up the tag array,
// services misses from memory and fills a victim way.
module l2_access_controller #(
    parameter int TAG_WIDTH    = 12,
    parameter int INDEX_WIDTH  = 10,
    parameter int OFFSET_WIDTH = 6,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                                       clock,
    input  logic                                       reset_n,
    input  logic                                       req0Valid,
    input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] req0Addr,
    output logic                                       req0Ready,
    input  logic                                       req1Valid,
    input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] req1Addr,
    output logic                                       req1Ready,
    output logic                                       respValid,
    output logic                                       respId,
    output logic                                       respHit,
    output logic [DATA_WIDTH-1:0]                      respData,
    output logic                                       lookupValid,
    output logic [INDEX_WIDTH-1:0]                     lookupIndex,
    output logic [TAG_WIDTH-1:0]                       lookupTag,
    input  logic                                       hit,
    input  logic [DATA_WIDTH-1:0]                      lookupData,
    input  logic [7:0]                                 wayValid,
    output logic                                       memReqValid,
    input  logic                                       memReqReady,
    output logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] memReqAddr,
    input  logic                                       memRespValid,
    input  logic [DATA_WIDTH-1:0]                      memRespData,
    output logic                                       fillEn,
    output logic [INDEX_WIDTH-1:0]                     fillIndex,
    output logic [2:0]                                 fillWay,
    output logic [TAG_WIDTH-1:0]                       fillTag,
    output logic [DATA_WIDTH-1:0]                      fillData,
    output logic [15:0]                                hitCount,
    output logic [15:0]                                missCount
);

    localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, COMPARE, MISS_REQ, MISS_WAIT, FILL, RESPOND
    } state_t;

    state_t                  state_q;
    logic                    lastGrant_q;
    logic                    id_q;
    logic [7:0]              wayValid_q;
    logic [2:0]              victimPtr_q;
    logic                    respValid_q, respId_q, respHit_q;
    logic [DATA_WIDTH-1:0]   respData_q;
    logic                    lookupValid_q;
    logic [INDEX_WIDTH-1:0]  lookupIndex_q;
    logic [TAG_WIDTH-1:0]    lookupTag_q;
    logic                    memReqValid_q;
    logic [ADDR_WIDTH-1:0]   memReqAddr_q;
    logic                    fillEn_q;
    logic [INDEX_WIDTH-1:0]  fillIndex_q;
    logic [2:0]              fillWay_q;
    logic [TAG_WIDTH-1:0]    fillTag_q;
    logic [DATA_WIDTH-1:0]   fillData_q;
    logic [15:0]             hitCount_q, missCount_q;

    logic                    grant0_d, grant1_d;
    logic [ADDR_WIDTH-1:0]   reqAddr_d;
    logic                    freeFound_d;
    logic [2:0]              freeWay_d;
    logic [15:0]             hitInc_d, missInc_d;
    logic                    unused_offset;

    // Round-robin: on a tie the port that did not win last time goes
    assign grant0_d  = (state_q == IDLE) && req0Valid && (!req1Valid || lastGrant_q);
    assign grant1_d  = (state_q == IDLE) && req1Valid && (!req0Valid || !lastGrant_q);
    assign req0Ready = grant0_d;
    assign req1Ready = grant1_d;
    assign reqAddr_d = grant1_d ? req1Addr : req0Addr;

    // Byte offset never matters to a line-granular lookup
    assign unused_offset = ^{req0Addr[OFFSET_WIDTH-1:0], req1Addr[OFFSET_WIDTH-1:0]};

    assign hitInc_d  = (hitCount_q == 16'hFFFF) ? hitCount_q : hitCount_q + 16'd1;
    assign missInc_d = (missCount_q == 16'hFFFF) ? missCount_q : missCount_q + 16'd1;

    // Lowest-numbered invalid way of the looked-up set
    always_comb begin
        freeFound_d = 1'b0;
        freeWay_d   = 3'd0;
        for (int w = 7; w >= 0; w--) begin
            if (!wayValid_q[w]) begin
                freeFound_d = 1'b1;
                freeWay_d   = 3'(w);
            end
        end
    end

    // Access sequencer with registered, state-decoded outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            lastGrant_q   <= 1'b1;
            id_q          <= 1'b0;
            wayValid_q    <= 8'd0;
            victimPtr_q   <= 3'd0;
            respValid_q   <= 1'b0;
            respId_q      <= 1'b0;
            respHit_q     <= 1'b0;
            respData_q    <= '0;
            lookupValid_q <= 1'b0;
            lookupIndex_q <= '0;
            lookupTag_q   <= '0;
            memReqValid_q <= 1'b0;
            memReqAddr_q  <= '0;
            fillEn_q      <= 1'b0;
            fillIndex_q   <= '0;
            fillWay_q     <= 3'd0;
            fillTag_q     <= '0;
            fillData_q    <= '0;
            hitCount_q    <= 16'd0;
            missCount_q   <= 16'd0;
        end else begin
            lookupValid_q <= 1'b0;
            fillEn_q      <= 1'b0;
            respValid_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant0_d || grant1_d) begin
                        id_q          <= grant1_d;
                        lastGrant_q   <= grant1_d;
                        lookupTag_q   <= reqAddr_d[ADDR_WIDTH-1 -: TAG_WIDTH];
                        lookupIndex_q <= reqAddr_d[OFFSET_WIDTH +: INDEX_WIDTH];
                        lookupValid_q <= 1'b1;
                        state_q       <= LOOKUP;
                    end
                end
                LOOKUP: state_q <= COMPARE;
                COMPARE: begin
                    wayValid_q <= wayValid;
                    if (hit) begin
                        respData_q  <= lookupData;
                        respHit_q   <= 1'b1;
                        respId_q    <= id_q;
                        respValid_q <= 1'b1;
                        hitCount_q  <= hitInc_d;
                        state_q     <= RESPOND;
                    end else begin
                        missCount_q   <= missInc_d;
                        memReqValid_q <= 1'b1;
                        memReqAddr_q  <= {lookupTag_q, lookupIndex_q,
                                          {OFFSET_WIDTH{1'b0}}};
                        state_q       <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (memReqReady) begin
                        memReqValid_q <= 1'b0;
                        state_q       <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (memRespValid) begin
                        fillEn_q    <= 1'b1;
                        fillIndex_q <= lookupIndex_q;
                        fillTag_q   <= lookupTag_q;
                        fillData_q  <= memRespData;
                        fillWay_q   <= freeFound_d ? freeWay_d : victimPtr_q;
                        if (!freeFound_d) begin
                            victimPtr_q <= victimPtr_q + 3'd1;
                        end
                        state_q     <= FILL;
                    end
                end
                FILL: begin
                    respValid_q <= 1'b1;
                    respHit_q   <= 1'b0;
                    respId_q    <= id_q;
                    respData_q  <= fillData_q;
                    state_q     <= RESPOND;
                end
                RESPOND: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign respValid   = respValid_q;
    assign respId      = respId_q;
    assign respHit     = respHit_q;
    assign respData    = respData_q;
    assign lookupValid = lookupValid_q;
    assign lookupIndex = lookupIndex_q;
    assign lookupTag   = lookupTag_q;
    assign memReqValid = memReqValid_q;
    assign memReqAddr  = memReqAddr_q;
    assign fillEn      = fillEn_q;
    assign fillIndex   = fillIndex_q;
    assign fillWay     = fillWay_q;
    assign fillTag     = fillTag_q;
    assign fillData    = fillData_q;
    assign hitCount    = hitCount_q;
    assign missCount   = missCount_q;

endmodule

// File: tb/tb_l2_access_controller.sv
// Scoreboard bench for l2_access_controller: directed hit/miss,
// victim rotation, arbitration, mid-miss reset and counter saturation.
module tb_l2_access_controller;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0Valid = 1'b0, req1Valid = 1'b0;
    logic [27:0] req0Addr = '0, req1Addr = '0;
    logic        req0Ready, req1Ready;
    logic        respValid, respId, respHit;
    logic [7:0]  respData;
    logic        lookupValid;
    logic [9:0]  lookupIndex;
    logic [11:0] lookupTag;
    logic        hit = 1'b0;
    logic [7:0]  lookupData = '0;
    logic [7:0]  wayValid = '0;
    logic        memReqValid;
    logic        memReqReady = 1'b0;
    logic [27:0] memReqAddr;
    logic        memRespValid = 1'b0;
    logic [7:0]  memRespData = '0;
    logic        fillEn;
    logic [9:0]  fillIndex;
    logic [2:0]  fillWay;
    logic [11:0] fillTag;
    logic [7:0]  fillData;
    logic [15:0] hitCount, missCount;

    l2_access_controller dut (
        .clock(clock), .reset_n(reset_n),
        .req0Valid(req0Valid), .req0Addr(req0Addr), .req0Ready(req0Ready),
        .req1Valid(req1Valid), .req1Addr(req1Addr), .req1Ready(req1Ready),
        .respValid(respValid), .respId(respId), .respHit(respHit),
        .respData(respData),
        .lookupValid(lookupValid), .lookupIndex(lookupIndex),
        .lookupTag(lookupTag),
        .hit(hit), .lookupData(lookupData), .wayValid(wayValid),
        .memReqValid(memReqValid), .memReqReady(memReqReady),
        .memReqAddr(memReqAddr),
        .memRespValid(memRespValid), .memRespData(memRespData),
        .fillEn(fillEn), .fillIndex(fillIndex), .fillWay(fillWay),
        .fillTag(fillTag), .fillData(fillData),
        .hitCount(hitCount), .missCount(missCount)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int resp_seen = 0;
    int fill_seen = 0;
    logic [15:0] exp_hc = 16'd0;
    logic [15:0] exp_mc = 16'd0;
    logic [41:0] resp_q[$];
    logic [32:0] fill_q[$];

    wire all_outs = |{respValid, respId, respHit, respData, lookupValid,
                      lookupIndex, lookupTag, memReqValid, memReqAddr,
                      fillEn, fillIndex, fillWay, fillTag, fillData,
                      hitCount, missCount, req0Ready, req1Ready};

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Monitor: pops expectations whenever the DUT strobes a response or fill
    always @(posedge clock) begin
        #1;
        if (respValid) begin
            resp_seen++;
            if (resp_q.size() == 0) begin
                check("unexpected_resp", {respId, respHit, respData}, 64'hDEAD);
            end else begin
                check("resp", {respId, respHit, respData, hitCount, missCount},
                      resp_q.pop_front());
            end
        end
        if (fillEn) begin
            fill_seen++;
            if (fill_q.size() == 0) begin
                check("unexpected_fill", {fillWay, fillData}, 64'hDEAD);
            end else begin
                check("fill", {fillWay, fillData, fillTag, fillIndex},
                      fill_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        exp_hc = 16'd0;
        exp_mc = 16'd0;
    endtask

    task automatic wait_ready(input int p, output bit ok);
        int n;
        n = 0;
        #1;
        while (!(p == 0 ? req0Ready : req1Ready) && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        ok = (n < 50);
        if (!ok) check("ready_timeout", 64'd0, 64'd1);
    endtask

    // One request; for misses, also plays the memory side
    task automatic do_txn(input int p, input logic [27:0] a, input logic h,
                          input logic [7:0] d, input logic [7:0] wv,
                          input int rdly, input logic [2:0] ew);
        bit ok;
        bit stable;
        int n;
        logic [27:0] a0;
        hit = h;
        lookupData = h ? d : 8'h00;
        wayValid = wv;
        if (p == 0) begin req0Valid = 1'b1; req0Addr = a; end
        else begin req1Valid = 1'b1; req1Addr = a; end
        wait_ready(p, ok);
        if (!ok) begin
            req0Valid = 1'b0;
            req1Valid = 1'b0;
            return;
        end
        if (h) begin
            exp_hc = sat(exp_hc);
            resp_q.push_back({p[0], 1'b1, d, exp_hc, exp_mc});
        end else begin
            exp_mc = sat(exp_mc);
            fill_q.push_back({ew, d, a[27:16], a[15:6]});
            resp_q.push_back({p[0], 1'b0, d, exp_hc, exp_mc});
        end
        @(posedge clock);
        #1;
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        if (h) begin
            repeat (2) @(posedge clock);
            #1;
            check("hit_latency", respValid, 1'b1);
            @(negedge clock);
            return;
        end
        n = 0;
        @(negedge clock);
        while (!memReqValid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("memreq_seen", memReqValid, 1'b1);
        check("memreq_addr", memReqAddr, a & ~28'h3F);
        a0 = memReqAddr;
        stable = 1'b1;
        repeat (rdly) begin
            @(negedge clock);
            if (!(memReqValid && memReqAddr == a0)) stable = 1'b0;
        end
        if (rdly > 0) check("memreq_stable", stable, 1'b1);
        memReqReady = 1'b1;
        @(negedge clock);
        memReqReady = 1'b0;
        @(negedge clock);
        memRespValid = 1'b1;
        memRespData = d;
        @(negedge clock);
        memRespValid = 1'b0;
        n = 0;
        while (!respValid && n < 10) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("miss_resp_seen", respValid, 1'b1);
        @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int g;
        int rs, fs;

        do_reset();
        #1;
        check("reset_outs_zero", all_outs, 1'b0);
        check("reset_last_grant", dut.lastGrant_q, 1'b1);

        // Single hit from L1-I
        do_txn(0, 28'h0041240, 1'b1, 8'hA5, 8'hFF, 0, 3'd0);

        // Miss into an invalid way with a stalled memory request
        do_txn(1, 28'h1234567, 1'b0, 8'h3C, 8'b1111_0111, 2, 3'd3);

        // Full sets: the victim pointer walks 0..7 and wraps
        for (int i = 0; i < 9; i++) begin
            do_txn(0, 28'h0100000 + 28'(i << 6), 1'b0, 8'h10 + 8'(i),
                   8'hFF, 0, 3'(i % 8));
        end

        // Reset while waiting for memory data
        @(negedge clock);
        hit = 1'b0;
        wayValid = 8'hFF;
        req0Valid = 1'b1;
        req0Addr = 28'h0ABCDC0;
        wait_ready(0, ok);
        @(posedge clock);
        #1;
        req0Valid = 1'b0;
        repeat (4) @(negedge clock);
        check("midmiss_memreq", memReqValid, 1'b1);
        memReqReady = 1'b1;
        @(negedge clock);
        memReqReady = 1'b0;
        @(negedge clock);
        rs = resp_seen;
        fs = fill_seen;
        reset_n = 1'b0;
        #1;
        check("midmiss_reset_zero", all_outs, 1'b0);
        exp_hc = 16'd0;
        exp_mc = 16'd0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        memRespValid = 1'b1;
        memRespData = 8'h77;
        @(negedge clock);
        memRespValid = 1'b0;
        repeat (5) @(negedge clock);
        check("midmiss_no_resp", resp_seen - rs, 0);
        check("midmiss_no_fill", fill_seen - fs, 0);
        do_txn(0, 28'h0041240, 1'b1, 8'h5A, 8'hFF, 0, 3'd0);

        // Arbitration: lone req1 after reset, then continuous contention
        do_reset();
        req1Valid = 1'b1;
        req1Addr = 28'h0200040;
        #1;
        check("lone_req1_ready", {req0Ready, req1Ready}, 2'b01);
        do_txn(1, 28'h0200040, 1'b1, 8'h11, 8'hFF, 0, 3'd0);
        // lastGrant is now 1, so contention yields 0,1,0,1
        hit = 1'b1;
        lookupData = 8'hC3;
        req0Valid = 1'b1;
        req0Addr = 28'h0300000;
        req1Valid = 1'b1;
        req1Addr = 28'h0400000;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            #1;
            while (!(req0Ready || req1Ready) && n < 50) begin
                @(negedge clock);
                #1;
                n++;
            end
            g = req1Ready ? 1 : 0;
            check("arb_grant", g, k % 2);
            check("arb_onehot", req0Ready & req1Ready, 1'b0);
            exp_hc = sat(exp_hc);
            resp_q.push_back({g[0], 1'b1, 8'hC3, exp_hc, exp_mc});
            @(posedge clock);
            @(negedge clock);
        end
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        repeat (4) @(negedge clock);

        // Saturation: preload 0xFFFE, then three hits
        force dut.hitCount_q = 16'hFFFE;
        @(negedge clock);
        release dut.hitCount_q;
        exp_hc = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            do_txn(i % 2, 28'h0500000 + 28'(i << 6), 1'b1, 8'hE0 + 8'(i),
                   8'hFF, 0, 3'd0);
        end
        check("hit_saturated", hitCount, 16'hFFFF);

        repeat (5) @(negedge clock);
        check("resp_q_drained", resp_q.size(), 0);
        check("fill_q_drained", fill_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
